seg_wr_buffer: RTL

SEG_WR_BUFFER -- requirements
Module: seg_wr_buffer

---
 rtl/seg_wr_buffer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seg_wr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : seg_wr_buffer
// Description : Segment-register write buffer. Pending writes are held in a
//               circular FIFO and drained in order to the segment register
//               file through the wr_* port. Two read indices can be checked
//               against the pending entries. pend1/pend2 report a
//               matching outstanding write. fwd_data1/fwd_data2 return the
//               youngest matching buffered value.
//
//               Optional feature macro: SEG_WR_BUFFER_FWD_EN
//                 defined   -> youngest-match forwarding on fwd_data1/2
//                 undefined -> fwd_data1/2 tied to 16'h0000 (pend still live)
//
// Ports       : clk         - single clock, rising edge
//               rst_n       - synchronous active-low reset
//               push_valid  - producer enqueue request
//               push_reg    - target segment register index
//               push_data   - segment selector value
//               push_ready  - buffer can accept an entry this cycle
//               drain_hold  - inhibit draining this cycle
//               wr_en/wr_reg/wr_data - register-file write port (head entry)
//               seg1/seg2   - register-file read indices
//               pend1/pend2 - outstanding buffered write to seg1/seg2
//               fwd_data1/2 - youngest buffered value for seg1/seg2
//
// Revision    : 1.0 - initial release
// ============================================================================
module seg_wr_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_valid,
    input  logic [2:0]  push_reg,
    input  logic [15:0] push_data,
    output logic        push_ready,
    input  logic        drain_hold,
    output logic        wr_en,
    output logic [2:0]  wr_reg,
    output logic [15:0] wr_data,
    input  logic [2:0]  seg1,
    input  logic [2:0]  seg2,
    output logic        pend1,
    output logic        pend2,
    output logic [15:0] fwd_data1,
    output logic [15:0] fwd_data2
);

    localparam int               c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0]    c_FULL     = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]    c_CNT_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0]  c_PTR_ONE  = c_AW'(1);

    // ------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------
    logic [c_AW-1:0] r_head;
    logic [c_AW-1:0] r_tail;
    logic [c_AW:0]   r_count;
    logic [2:0]      r_reg_mem  [DEPTH];
    logic [15:0]     r_data_mem [DEPTH];

    logic            w_push;
    logic            w_pop;

    // Ready comes from the registered count only, so a drain in the same
    // cycle never opens a slot for a push while full.
    assign push_ready = (r_count != c_FULL);
    assign w_push     = push_valid && push_ready;

    // The head entry is driven straight from storage; a push lands at the
    // tail and only becomes visible here after the next clock edge.
    assign wr_en   = (r_count != '0) && !drain_hold;
    assign w_pop   = wr_en;
    assign wr_reg  = r_reg_mem[r_head];
    assign wr_data = r_data_mem[r_head];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload is not reset; pointers and count define validity, so
    // stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg_mem[r_tail]  <= push_reg;
            r_data_mem[r_tail] <= push_data;
        end
    end

    // ------------------------------------------------------------------
    // Per-slot validity and match against the read indices.
    // Age is the slot's distance from the head: 0 = oldest. A slot is
    // live when its age is below the occupancy count. The head being
    // drained this cycle is still live, so pend stays up until the write
    // has actually reached the register file.
    // ------------------------------------------------------------------
    logic [c_AW-1:0] w_age [DEPTH];
    logic [DEPTH-1:0] w_live;
    logic [DEPTH-1:0] w_hit1;
    logic [DEPTH-1:0] w_hit2;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign w_age[i]  = c_AW'(i) - r_head;
        assign w_live[i] = ({1'b0, w_age[i]} < r_count);
        assign w_hit1[i] = w_live[i] && (r_reg_mem[i] == seg1);
        assign w_hit2[i] = w_live[i] && (r_reg_mem[i] == seg2);
    end

    assign pend1 = |w_hit1;
    assign pend2 = |w_hit2;

`ifdef SEG_WR_BUFFER_FWD_EN
    // Youngest match = matching live slot with the largest age. Ages of
    // live slots are distinct, so there is never a tie to resolve.
    logic            w_found1;
    logic            w_found2;
    logic [c_AW-1:0] w_best1;
    logic [c_AW-1:0] w_best2;

    always_comb begin
        fwd_data1 = '0;
        fwd_data2 = '0;
        w_found1  = 1'b0;
        w_found2  = 1'b0;
        w_best1   = '0;
        w_best2   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_hit1[i] && (!w_found1 || (w_age[i] > w_best1))) begin
                w_found1  = 1'b1;
                w_best1   = w_age[i];
                fwd_data1 = r_data_mem[i];
            end
            if (w_hit2[i] && (!w_found2 || (w_age[i] > w_best2))) begin
                w_found2  = 1'b1;
                w_best2   = w_age[i];
                fwd_data2 = r_data_mem[i];
            end
        end
    end
`else
    // Forwarding not built: consumers rely on pend1/pend2 to stall.
    assign fwd_data1 = 16'h0000;
    assign fwd_data2 = 16'h0000;
`endif

endmodule
`default_nettype wire
